// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the 8-bit ALU: handshake, operand read, execute, write-back.
// Owns the architectural {Z,C,N,V} flag register and feeds C back as the ALU carry-in.
module alu_sequencer #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] req_class_i,
    input  logic [1:0] req_fn_i,
    input  logic [2:0] req_rd_i,
    input  logic [2:0] req_rs_i,
    input  logic [2:0] req_rs2_i,
    input  logic       req_use_imm_i,
    input  logic [7:0] req_imm_i,
    input  logic [2:0] req_count_i,
    output logic [2:0] rf_raddr_a_o,
    output logic [2:0] rf_raddr_b_o,
    input  logic [7:0] rf_rdata_a_i,
    input  logic [7:0] rf_rdata_b_i,
    output logic       rf_we_o,
    output logic [2:0] rf_waddr_o,
    output logic [7:0] rf_wdata_o,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    output logic [2:0] alu_count_o,
    output logic [3:0] alu_op_o,
    output logic       alu_cin_o,
    input  logic [7:0] alu_res_i,
    input  logic       alu_v_i,
    input  logic       alu_c_i,
    input  logic       flag_load_i,
    input  logic [3:0] flag_load_val_i,
    output logic       flag_z_o,
    output logic       flag_c_o,
    output logic       flag_n_o,
    output logic       flag_v_o,
    output logic       busy_o,
    output logic       done_o
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

    typedef struct packed {
        logic [1:0] cls;
        logic [1:0] fn;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rs2;
        logic       use_imm;
        logic [7:0] imm;
        logic [2:0] count;
    } req_t;

    localparam logic [1:0] CLASS_SHIFT = 2'b10;

    state_e     state_q, state_d;
    req_t       req_q, req_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [2:0] alu_count_q, alu_count_d;
    logic [2:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [3:0] flags_q, flags_d;
    logic       handshake;

    assign req_ready_o = (state_q == IDLE) || (state_q == WB);
    assign handshake   = req_valid_i && req_ready_o;

    // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_count_d = alu_count_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        flags_d     = flags_q;

        if (flag_load_i) begin
            flags_d = flag_load_val_i;
        end

        if (handshake) begin
            req_d.cls     = (req_class_i == 2'b11) ? CLASS_SHIFT : req_class_i;
            req_d.fn      = req_fn_i;
            req_d.rd      = req_rd_i;
            req_d.rs      = req_rs_i;
            req_d.rs2     = req_rs2_i;
            req_d.use_imm = req_use_imm_i;
            req_d.imm     = req_imm_i;
            req_d.count   = req_count_i;
        end

        case (state_q)
            IDLE: if (handshake) state_d = READ;
            READ: begin
                state_d     = EXEC;
                alu_a_d     = rf_rdata_a_i;
                alu_b_d     = (req_q.cls == CLASS_SHIFT) ? 8'h00 :
                              req_q.use_imm              ? req_q.imm : rf_rdata_b_i;
                alu_op_d    = {req_q.cls, req_q.fn};
                alu_count_d = req_q.count;
            end
            EXEC: begin
                // Capture overrides a coincident flag load; N comes from the result MSB.
                state_d = WB;
                waddr_d = req_q.rd;
                wdata_d = alu_res_i;
                flags_d = {(alu_res_i == 8'h00), alu_c_i, alu_res_i[7], alu_v_i};
            end
            WB:      state_d = handshake ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_count_q <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            flags_q     <= FLAG_RESET;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_count_q <= alu_count_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            flags_q     <= flags_d;
        end
    end

    assign rf_raddr_a_o = req_q.rs;
    assign rf_raddr_b_o = req_q.rs2;
    assign rf_we_o      = (state_q == WB) && (waddr_q != 3'd0);
    assign rf_waddr_o   = waddr_q;
    assign rf_wdata_o   = wdata_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign alu_count_o  = alu_count_q;
    assign alu_cin_o    = flags_q[2];
    assign flag_z_o     = flags_q[3];
    assign flag_c_o     = flags_q[2];
    assign flag_n_o     = flags_q[1];
    assign flag_v_o     = flags_q[0];
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == WB);
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and register file around the DUT, with a
// reference model filling a scoreboard at each handshake and a monitor draining it at done_o.
module tb_alu_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [1:0] req_class_i;
    logic [1:0] req_fn_i;
    logic [2:0] req_rd_i, req_rs_i, req_rs2_i;
    logic       req_use_imm_i;
    logic [7:0] req_imm_i;
    logic [2:0] req_count_i;
    logic [2:0] rf_raddr_a_o, rf_raddr_b_o;
    logic [7:0] rf_rdata_a_i, rf_rdata_b_i;
    logic       rf_we_o;
    logic [2:0] rf_waddr_o;
    logic [7:0] rf_wdata_o;
    logic [7:0] alu_a_o, alu_b_o;
    logic [2:0] alu_count_o;
    logic [3:0] alu_op_o;
    logic       alu_cin_o;
    logic [7:0] alu_res_i;
    logic       alu_v_i, alu_c_i;
    logic       flag_load_i;
    logic [3:0] flag_load_val_i;
    logic       flag_z_o, flag_c_o, flag_n_o, flag_v_o;
    logic       busy_o, done_o;

    alu_sequencer #(.FLAG_RESET(4'b0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_class_i(req_class_i), .req_fn_i(req_fn_i),
        .req_rd_i(req_rd_i), .req_rs_i(req_rs_i), .req_rs2_i(req_rs2_i),
        .req_use_imm_i(req_use_imm_i), .req_imm_i(req_imm_i), .req_count_i(req_count_i),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_count_o(alu_count_o),
        .alu_op_o(alu_op_o), .alu_cin_o(alu_cin_o),
        .alu_res_i(alu_res_i), .alu_v_i(alu_v_i), .alu_c_i(alu_c_i),
        .flag_load_i(flag_load_i), .flag_load_val_i(flag_load_val_i),
        .flag_z_o(flag_z_o), .flag_c_o(flag_c_o), .flag_n_o(flag_n_o), .flag_v_o(flag_v_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] res;
        logic       we;
        logic [3:0] flags;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    int         cyc = 0;
    logic [7:0] rf[8];
    logic [7:0] model_rf[8];
    logic [3:0] model_f;
    logic       pre_we;
    logic [2:0] pre_addr;
    logic [7:0] pre_data;

    // Behavioural ALU: returns {result, carry, overflow}; op 11xx is illegal and yields garbage.
    function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] cnt, input logic cin);
        logic [8:0]  s;
        logic [15:0] t;
        logic [7:0]  r;
        logic        c, v;
        s = '0; t = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: begin s = {1'b0, a} + {1'b0, b};               r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'b0001: begin s = {1'b0, a} + {1'b0, b} + {8'h00, cin}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'b0010: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1;        r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'b0011: begin s = {1'b0, a} + {1'b0, ~b} + {8'h00, cin}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~a;
            4'b1000: begin t = {8'h00, a} << cnt; r = t[7:0];  c = (cnt != 0) && t[8]; end
            4'b1001: begin t = {a, 8'h00} >> cnt; r = t[15:8]; c = (cnt != 0) && t[7]; end
            4'b1010: begin t = {a, a} << cnt;     r = t[15:8]; c = (cnt != 0) && r[0]; end
            4'b1011: begin t = {a, a} >> cnt;     r = t[7:0];  c = (cnt != 0) && r[7]; end
            default: begin r = 8'hEE; c = 1'b1; v = 1'b1; end
        endcase
        return {r, c, v};
    endfunction

    always_comb {alu_res_i, alu_c_i, alu_v_i} = alu_fn(alu_op_o, alu_a_o, alu_b_o, alu_count_o, alu_cin_o);

    assign rf_rdata_a_i = rf[rf_raddr_a_o];
    assign rf_rdata_b_i = rf[rf_raddr_b_o];

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (rf_we_o) rf[rf_waddr_o] <= rf_wdata_o;
    end

    // Scoreboard monitor: every done_o pops one expected write-back.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (done_o) begin
                chk_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_done: done_o=1 with no operation outstanding");
                end else begin
                    pass_cnt++;
                    mon_e = sb.pop_front();
                    chk_cnt++;
                    if (rf_we_o !== mon_e.we) $display("FAIL wb_we: got %b expected %b", rf_we_o, mon_e.we);
                    else pass_cnt++;
                    chk_cnt++;
                    if (rf_waddr_o !== mon_e.rd) $display("FAIL wb_addr: got %0d expected %0d", rf_waddr_o, mon_e.rd);
                    else pass_cnt++;
                    chk_cnt++;
                    if (rf_wdata_o !== mon_e.res) $display("FAIL wb_data: got %h expected %h", rf_wdata_o, mon_e.res);
                    else pass_cnt++;
                    chk_cnt++;
                    if ({flag_z_o, flag_c_o, flag_n_o, flag_v_o} !== mon_e.flags)
                        $display("FAIL wb_flags: got %b expected %b", {flag_z_o, flag_c_o, flag_n_o, flag_v_o}, mon_e.flags);
                    else pass_cnt++;
                    chk_cnt++;
                    if (cyc - mon_e.cyc !== 3) $display("FAIL latency: got %0d cycles expected 3", cyc - mon_e.cyc);
                    else pass_cnt++;
                end
            end else begin
                chk_cnt++;
                if (rf_we_o !== 1'b0) $display("FAIL stray_we: rf_we_o=%b outside WB, expected 0", rf_we_o);
                else pass_cnt++;
            end
        end
    end

    task automatic set_reg(input logic [2:0] addr, input logic [7:0] data);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        model_rf[addr] = data;
        @(posedge clk_i);
        #1 pre_we = 1'b0;
    endtask

    task automatic load_flags(input logic [3:0] v);
        flag_load_i = 1'b1; flag_load_val_i = v;
        @(posedge clk_i);
        #1 flag_load_i = 1'b0;
        model_f = v;
    endtask

    task automatic issue(input logic [1:0] cls, input logic [1:0] fn, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rs2, input logic use_imm,
                         input logic [7:0] imm, input logic [2:0] cnt, output int k);
        exp_t       e;
        int         n;
        logic [1:0] c;
        logic [7:0] a, b;
        logic [9:0] r;
        req_class_i = cls; req_fn_i = fn; req_rd_i = rd; req_rs_i = rs; req_rs2_i = rs2;
        req_use_imm_i = use_imm; req_imm_i = imm; req_count_i = cnt; req_valid_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk_cnt++;
        if (req_ready_o !== 1'b1) $display("FAIL issue_ready: ready=%b expected 1 within 20 cycles", req_ready_o);
        else pass_cnt++;
        k = cyc;
        @(posedge clk_i);
        c = (cls == 2'b11) ? 2'b10 : cls;
        a = model_rf[rs];
        b = (c == 2'b10) ? 8'h00 : (use_imm ? imm : model_rf[rs2]);
        r = alu_fn({c, fn}, a, b, cnt, model_f[2]);
        e.rd = rd; e.res = r[9:2]; e.we = (rd != 3'd0); e.cyc = k;
        e.flags = {(r[9:2] == 8'h00), r[1], r[9], r[0]};
        model_f = e.flags;
        if (rd != 3'd0) model_rf[rd] = r[9:2];
        sb.push_back(e);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk_i);
        while ((sb.size() != 0 || busy_o) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk_cnt++;
        if (sb.size() != 0 || busy_o !== 1'b0)
            $display("FAIL drain: %0d outstanding, busy_o=%b, expected 0/0", sb.size(), busy_o);
        else pass_cnt++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #3;
        chk_cnt++;
        if ({req_ready_o, busy_o, done_o, rf_we_o} !== 4'b1000)
            $display("FAIL reset_ctrl: ready/busy/done/we=%b expected 1000", {req_ready_o, busy_o, done_o, rf_we_o});
        else pass_cnt++;
        chk_cnt++;
        if ({rf_waddr_o, rf_wdata_o, alu_a_o, alu_b_o, alu_op_o, alu_count_o} !== '0)
            $display("FAIL reset_data: waddr=%0d wdata=%h a=%h b=%h op=%h cnt=%0d expected all 0",
                     rf_waddr_o, rf_wdata_o, alu_a_o, alu_b_o, alu_op_o, alu_count_o);
        else pass_cnt++;
        chk_cnt++;
        if ({flag_z_o, flag_c_o, flag_n_o, flag_v_o} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {flag_z_o, flag_c_o, flag_n_o, flag_v_o});
        else pass_cnt++;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_f = 4'b0000;
        for (int i = 0; i < 8; i++) set_reg(3'(i), (i == 0) ? 8'h00 : 8'($urandom));
    endtask

    task automatic test_flag_load_idle();
        load_flags(4'b1010);
        chk_cnt++;
        if ({flag_z_o, flag_c_o, flag_n_o, flag_v_o, alu_cin_o} !== 5'b10100)
            $display("FAIL flag_load_idle: flags/cin=%b expected 10100", {flag_z_o, flag_c_o, flag_n_o, flag_v_o, alu_cin_o});
        else pass_cnt++;
    endtask

    task automatic test_add();
        int k;
        set_reg(3'd1, 8'h7F);
        set_reg(3'd2, 8'h01);
        issue(2'b00, 2'b00, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 3'd0, k);
        wait_drain();
        chk_cnt++;
        if (rf[3] !== 8'h80 || {flag_z_o, flag_c_o, flag_n_o, flag_v_o} !== 4'b0011)
            $display("FAIL add: r3=%h flags=%b expected 80 0011", rf[3], {flag_z_o, flag_c_o, flag_n_o, flag_v_o});
        else pass_cnt++;
    endtask

    task automatic test_addc();
        int k;
        set_reg(3'd5, 8'hFF);
        load_flags(4'b0100);
        issue(2'b00, 2'b01, 3'd4, 3'd5, 3'd0, 1'b1, 8'h00, 3'd0, k);
        wait_drain();
        chk_cnt++;
        if (rf[4] !== 8'h00 || {flag_z_o, flag_c_o, flag_n_o, flag_v_o} !== 4'b1100)
            $display("FAIL addc: r4=%h flags=%b expected 00 1100", rf[4], {flag_z_o, flag_c_o, flag_n_o, flag_v_o});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int k1, k2;
        set_reg(3'd1, 8'h81);
        issue(2'b01, 2'b00, 3'd0, 3'd1, 3'd0, 1'b1, 8'h00, 3'd0, k1);
        issue(2'b10, 2'b00, 3'd1, 3'd1, 3'd0, 1'b0, 8'h00, 3'd1, k2);
        chk_cnt++;
        if (k2 - k1 !== 3) $display("FAIL b2b_accept: second accepted %0d cycles after first, expected 3", k2 - k1);
        else pass_cnt++;
        wait_drain();
        chk_cnt++;
        if (rf[1] !== 8'h02 || flag_c_o !== 1'b1 || rf[0] !== 8'h00)
            $display("FAIL b2b_shl: r1=%h C=%b r0=%h expected 02 1 00", rf[1], flag_c_o, rf[0]);
        else pass_cnt++;
    endtask

    task automatic test_raw();
        int k;
        set_reg(3'd1, 8'h10);
        issue(2'b00, 2'b00, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01, 3'd0, k);
        issue(2'b01, 2'b01, 3'd6, 3'd2, 3'd0, 1'b1, 8'h00, 3'd0, k);
        wait_drain();
        chk_cnt++;
        if (rf[2] !== 8'h11 || rf[6] !== 8'h11)
            $display("FAIL raw: r2=%h r6=%h expected 11 11", rf[2], rf[6]);
        else pass_cnt++;
    endtask

    task automatic test_class3();
        int k;
        set_reg(3'd7, 8'hB4);
        issue(2'b11, 2'b01, 3'd7, 3'd7, 3'd3, 1'b1, 8'h55, 3'd2, k);
        wait_drain();
        chk_cnt++;
        if (rf[7] !== 8'h2D) $display("FAIL class3_shr: r7=%h expected 2d", rf[7]);
        else pass_cnt++;
    endtask

    task automatic test_flag_exec();
        int k;
        set_reg(3'd1, 8'h01);
        issue(2'b00, 2'b00, 3'd5, 3'd1, 3'd0, 1'b1, 8'h01, 3'd0, k);
        @(posedge clk_i);
        #1 flag_load_i = 1'b1; flag_load_val_i = 4'b1111;
        @(posedge clk_i);
        #1 flag_load_i = 1'b0;
        chk_cnt++;
        if ({flag_z_o, flag_c_o, flag_n_o, flag_v_o} !== 4'b0000)
            $display("FAIL flag_exec_collision: flags=%b expected 0000", {flag_z_o, flag_c_o, flag_n_o, flag_v_o});
        else pass_cnt++;
        wait_drain();
    endtask

    task automatic test_random_burst();
        int k;
        for (int i = 0; i < 12; i++)
            issue(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 8'($urandom), 3'($urandom), k);
        wait_drain();
        for (int i = 0; i < 8; i++) begin
            chk_cnt++;
            if (rf[i] !== model_rf[i]) $display("FAIL burst_rf: r%0d=%h expected %h", i, rf[i], model_rf[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_exec();
        int k;
        set_reg(3'd3, 8'h5A);
        set_reg(3'd1, 8'h22);
        load_flags(4'b1111);
        issue(2'b00, 2'b00, 3'd3, 3'd1, 3'd0, 1'b1, 8'h01, 3'd0, k);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk_cnt++;
        if ({req_ready_o, busy_o, done_o, rf_we_o, flag_z_o, flag_c_o, flag_n_o, flag_v_o} !== 8'b1000_0000)
            $display("FAIL reset_exec: ready/busy/done/we/flags=%b expected 10000000",
                     {req_ready_o, busy_o, done_o, rf_we_o, flag_z_o, flag_c_o, flag_n_o, flag_v_o});
        else pass_cnt++;
        sb.delete();
        model_rf[3] = 8'h5A;
        model_f = 4'b0000;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        chk_cnt++;
        if (rf[3] !== 8'h5A || busy_o !== 1'b0) $display("FAIL reset_abort: r3=%h busy=%b expected 5a 0", rf[3], busy_o);
        else pass_cnt++;
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_class_i = '0; req_fn_i = '0;
        req_rd_i = '0; req_rs_i = '0; req_rs2_i = '0; req_use_imm_i = 1'b0;
        req_imm_i = '0; req_count_i = '0; flag_load_i = 1'b0; flag_load_val_i = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0; model_f = 4'b0000;
        test_reset();
        test_flag_load_idle();
        test_add();
        test_addc();
        test_back_to_back();
        test_raw();
        test_class3();
        test_flag_exec();
        test_random_burst();
        test_reset_exec();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
